// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder
//   Receives PS/2 keyboard frames from the physical clock/data lines. It tracks the
//   E0 (extended), F0 (release) and E1 (pause) prefix bytes. For every make or break
//   code it emits one toggle-flagged 11-bit event on the ps2_key bus.
//
// Ports
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   ps2_clk_in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  raw PS/2 data line (asynchronous)
//   ps2_key      [10] toggles per event, [9] pressed, [8] extended, [7:0] scan code
//   frame_err    one-cycle pulse on parity, stop-bit or timeout error
module ps2_key_encoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 40000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]     clk_sync_q, data_sync_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall_q;
    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           ext_q, ext_d, rel_q, rel_d;
    logic [2:0]     skip_q, skip_d;
    logic [10:0]    key_q, key_d;
    logic           err_q, err_d;
    logic           byte_ok;
    logic           timeout;
    logic           clk_s, data_s;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // A new clock level is accepted only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign timeout = (state_q != StIdle) && (to_cnt_q >= TCW'(TIMEOUT));

    // Receiver FSM; a fall strobe in the same cycle as the timeout takes priority.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        byte_ok   = 1'b0;
        err_d     = 1'b0;
        to_cnt_d  = (fall_q || state_q == StIdle) ? '0 : to_cnt_q + 1'b1;
        if (timeout && !fall_q) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else if (fall_q) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = data_s;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    // Odd parity over data+parity, and stop bit must be high.
                    if ((^{shift_q, par_q}) && data_s) byte_ok = 1'b1;
                    else err_d = 1'b1;
                end
            endcase
        end
    end

    // Prefix tracking and event generation.
    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        key_d  = key_q;
        if (err_d) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_ok) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (shift_q == 8'hE1) begin
                // Pause key: swallow the remaining 7 bytes of its fixed sequence.
                skip_d = 3'd7;
            end else if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            fall_q      <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            rel_q       <= 1'b0;
            skip_q      <= 3'd0;
            key_q       <= 11'd0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            fall_q      <= filt_q & ~filt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            rel_q       <= rel_d;
            skip_q      <= skip_d;
            key_q       <= key_d;
            err_q       <= err_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: directed frame table, randomized frames
// against a reference model, and hand-written timeout, glitch and reset sequences.
module tb_ps2_key_encoder;

    localparam int unsigned FL   = 4;
    localparam int unsigned TO   = 500;
    localparam int unsigned HALF = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_encoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Output monitor
    int          err_pulses = 0;
    int          err_long = 0;
    int          toggles = 0;
    logic        prev_err = 1'b0;
    logic        prev_b10 = 1'b0;
    int unsigned last_err_cyc = 0;
    int unsigned last_fall_cyc = 0;

    always @(negedge clk_sys) begin
        if (frame_err === 1'b1) begin
            if (prev_err) err_long++;
            else begin
                err_pulses++;
                last_err_cyc = cyc;
            end
        end
        if (ps2_key[10] !== prev_b10) toggles++;
        prev_err = frame_err;
        prev_b10 = ps2_key[10];
    end

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: decode rules applied to whole bytes.
    logic [10:0] m_key = 11'd0;
    bit          m_ext = 1'b0;
    bit          m_rel = 1'b0;
    int          m_skip = 0;

    task automatic model_reset();
        m_key = 11'd0; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ext = 1'b0; m_rel = 1'b0;
        end else if (m_skip != 0) m_skip--;
        else if (b == 8'hE1) m_skip = 7;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
            m_key = {~m_key[10], ~m_rel, m_ext, b};
            m_ext = 1'b0; m_rel = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then clock low. Optional sub-filter glitches.
    task automatic send_bit(input logic b, input bit g);
        ps2_data_in = b;
        wait_cycles(8);
        if (g) begin
            ps2_clk_in = 1'b0; wait_cycles(2); ps2_clk_in = 1'b1; wait_cycles(HALF - 10);
        end else wait_cycles(HALF - 8);
        ps2_clk_in = 1'b0;
        last_fall_cyc = cyc;
        wait_cycles(8);
        if (g) begin
            ps2_clk_in = 1'b1; wait_cycles(2); ps2_clk_in = 1'b0; wait_cycles(HALF - 10);
        end else wait_cycles(HALF - 8);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip, input bit bad_stop,
                              input bit g);
        send_bit(1'b0, g);
        for (int i = 0; i < 8; i++) send_bit(b[i], g);
        send_bit(~(^b) ^ flip, g);
        send_bit(~bad_stop, g);
        ps2_data_in = 1'b1;
        wait_cycles(3 * HALF);
    endtask

    // Send, update model, compare key and error count against the model.
    task automatic apply(input string name, input logic [7:0] b, input bit flip,
                         input bit bad_stop, input bit g);
        int e0;
        e0 = err_pulses;
        send_frame(b, flip, bad_stop, g);
        model_frame(b, !flip && !bad_stop);
        check({name, "_key"}, 32'(ps2_key), 32'(m_key));
        check({name, "_err"}, 32'(err_pulses - e0), 32'(flip || bad_stop));
    endtask

    typedef struct {
        logic [7:0]  code;
        bit          flip;
        bit          bad_stop;
        bit          exp_err;
        logic [10:0] exp_key;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int e0;
        int t0;
        bit seen;
        logic [7:0] b;
        int r;

        vecs.push_back('{8'h1C, 0, 0, 0, 11'h61C});
        vecs.push_back('{8'hF0, 0, 0, 0, 11'h61C});
        vecs.push_back('{8'h1C, 0, 0, 0, 11'h01C});
        vecs.push_back('{8'hE0, 0, 0, 0, 11'h01C});
        vecs.push_back('{8'hF0, 0, 0, 0, 11'h01C});
        vecs.push_back('{8'h75, 0, 0, 0, 11'h575});
        vecs.push_back('{8'hE0, 0, 0, 0, 11'h575});
        vecs.push_back('{8'h75, 0, 0, 0, 11'h375});
        vecs.push_back('{8'h29, 1, 0, 1, 11'h375});
        vecs.push_back('{8'hE0, 0, 0, 0, 11'h375});
        vecs.push_back('{8'h29, 1, 0, 1, 11'h375});
        vecs.push_back('{8'h6B, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'hE1, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'h14, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'h77, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'hE1, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'hF0, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'h14, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'hF0, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'h77, 0, 0, 0, 11'h66B});
        vecs.push_back('{8'h5A, 0, 0, 0, 11'h25A});
        vecs.push_back('{8'h66, 0, 1, 1, 11'h25A});
        vecs.push_back('{8'hF0, 0, 0, 0, 11'h25A});
        vecs.push_back('{8'hE0, 0, 0, 0, 11'h25A});
        vecs.push_back('{8'h14, 0, 0, 0, 11'h514});
        vecs.push_back('{8'hF0, 0, 0, 0, 11'h514});
        vecs.push_back('{8'hF0, 0, 0, 0, 11'h514});
        vecs.push_back('{8'h14, 0, 0, 0, 11'h014});

        // Reset state
        wait_cycles(5);
        check("reset_key", 32'(ps2_key), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        wait_cycles(5);

        // Directed table
        t0 = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 12) t0 = toggles;
            e0 = err_pulses;
            send_frame(vecs[i].code, vecs[i].flip, vecs[i].bad_stop, 1'b0);
            model_frame(vecs[i].code, !vecs[i].flip && !vecs[i].bad_stop);
            check($sformatf("tbl%0d_key", i), 32'(ps2_key), 32'(vecs[i].exp_key));
            check($sformatf("tbl%0d_err", i), 32'(err_pulses - e0), 32'(vecs[i].exp_err));
            if (i == 20) check("pause_toggles", 32'(toggles - t0), 32'd1);
        end

        // Randomized frames against the model
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 15);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = 8'hE1;
            else b = 8'($urandom_range(0, 255));
            apply($sformatf("rnd%0d", i), b, ($urandom_range(0, 7) == 0), 1'b0, 1'b0);
        end

        // Reset mid-frame
        e0 = err_pulses;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        ps2_clk_in = 1'b1;
        ps2_data_in = 1'b1;
        wait_cycles(3);
        check("midrst_key", 32'(ps2_key), 32'd0);
        reset_n = 1'b1;
        model_reset();
        wait_cycles(10);
        apply("post_rst", 8'h1C, 1'b0, 1'b0, 1'b0);
        check("post_rst_const", 32'(ps2_key), 32'h61C);
        check("post_rst_noerr", 32'(err_pulses - e0), 32'd0);

        // Glitches shorter than the filter on every bit
        apply("glitch", 8'h33, 1'b0, 1'b0, 1'b1);

        // Timeout after 4 data bits, with an E0 pending that must be dropped
        apply("to_pre", 8'hE0, 1'b0, 1'b0, 1'b0);
        e0 = err_pulses;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < int'(TO) + 60 && !seen; i++) begin
            wait_cycles(1);
            if (err_pulses > e0) seen = 1'b1;
        end
        check("to_seen", 32'(seen), 32'd1);
        total++;
        if (seen && (last_err_cyc - last_fall_cyc) >= TO &&
            (last_err_cyc - last_fall_cyc) <= TO + FL + 10) passed++;
        else $display("FAIL to_latency: got %0d cycles expected %0d..%0d",
                      last_err_cyc - last_fall_cyc, TO, TO + FL + 10);
        wait_cycles(10);
        check("to_single", 32'(err_pulses - e0), 32'd1);
        model_frame(8'h00, 1'b0);
        apply("to_post", 8'h12, 1'b0, 1'b0, 1'b0);
        check("to_post_code", 32'(ps2_key[7:0]), 32'h12);
        check("to_post_ext", 32'(ps2_key[8]), 32'd0);

        check("err_width", 32'(err_long), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
